// File: rtl/mul_rs_if.sv
// Multiply RS bus: dispatch request, CDB snoop, FU availability and issue outputs.
// master = dispatch/CDB/FU environment, slave = the reservation station.
interface mul_rs_if #(parameter int PR_W = 7);
  logic            id_valid;
  logic [63:0]     id_NPC;
  logic [31:0]     id_IR;
  logic [PR_W-1:0] id_pra_idx;
  logic [PR_W-1:0] id_prb_idx;
  logic            id_pra_rdy;
  logic            id_prb_rdy;
  logic [4:0]      id_dest_ar_idx;
  logic [PR_W-1:0] id_dest_pr_idx;
  logic            cdb_valid0;
  logic            cdb_valid1;
  logic [PR_W-1:0] cdb_tag0;
  logic [PR_W-1:0] cdb_tag1;
  logic [1:0]      fu_avail;
  logic            rs_valid_inst0;
  logic [63:0]     rs_NPC0;
  logic [31:0]     rs_IR0;
  logic [PR_W-1:0] rs_pra_idx0;
  logic [PR_W-1:0] rs_prb_idx0;
  logic [4:0]      rs_dest_ar_idx0;
  logic [PR_W-1:0] rs_dest_pr_idx0;
  logic            rs_full;
  logic [3:0]      rs_count;

  modport master (
    output id_valid, id_NPC, id_IR, id_pra_idx, id_prb_idx, id_pra_rdy, id_prb_rdy,
           id_dest_ar_idx, id_dest_pr_idx, cdb_valid0, cdb_valid1, cdb_tag0, cdb_tag1, fu_avail,
    input  rs_valid_inst0, rs_NPC0, rs_IR0, rs_pra_idx0, rs_prb_idx0, rs_dest_ar_idx0,
           rs_dest_pr_idx0, rs_full, rs_count
  );

  modport slave (
    input  id_valid, id_NPC, id_IR, id_pra_idx, id_prb_idx, id_pra_rdy, id_prb_rdy,
           id_dest_ar_idx, id_dest_pr_idx, cdb_valid0, cdb_valid1, cdb_tag0, cdb_tag1, fu_avail,
    output rs_valid_inst0, rs_NPC0, rs_IR0, rs_pra_idx0, rs_prb_idx0, rs_dest_ar_idx0,
           rs_dest_pr_idx0, rs_full, rs_count
  );
endinterface

// File: rtl/mul_rs.sv
// Multiply reservation station: dispatch into lowest free entry, CDB wake-up,
// lowest-index select, registered single issue to multiplier slot 0.
module mul_rs_ent #(
  parameter int PR_W = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 wr,
  input  logic                 clr,
  input  logic [63:0]          wr_npc,
  input  logic [31:0]          wr_ir,
  input  logic [PR_W-1:0]      wr_tag_a,
  input  logic                 wr_rdy_a,
  input  logic [PR_W-1:0]      wr_tag_b,
  input  logic                 wr_rdy_b,
  input  logic [4:0]           wr_dest_ar,
  input  logic [PR_W-1:0]      wr_dest_pr,
  input  logic [1:0]           cdb_vld,
  input  logic [1:0][PR_W-1:0] cdb_tag,
  output logic                 valid,
  output logic                 rdy_a,
  output logic                 rdy_b,
  output logic [63:0]          npc,
  output logic [31:0]          ir,
  output logic [PR_W-1:0]      tag_a,
  output logic [PR_W-1:0]      tag_b,
  output logic [4:0]           dest_ar,
  output logic [PR_W-1:0]      dest_pr
);
  logic hit_a, hit_b;

  assign hit_a = (cdb_vld[0] && cdb_tag[0] == tag_a) || (cdb_vld[1] && cdb_tag[1] == tag_a);
  assign hit_b = (cdb_vld[0] && cdb_tag[0] == tag_b) || (cdb_vld[1] && cdb_tag[1] == tag_b);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid   <= 1'b0;
      rdy_a   <= 1'b0;
      rdy_b   <= 1'b0;
      npc     <= '0;
      ir      <= '0;
      tag_a   <= '0;
      tag_b   <= '0;
      dest_ar <= '0;
      dest_pr <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (wr) begin
      valid   <= 1'b1;
      rdy_a   <= wr_rdy_a;
      rdy_b   <= wr_rdy_b;
      npc     <= wr_npc;
      ir      <= wr_ir;
      tag_a   <= wr_tag_a;
      tag_b   <= wr_tag_b;
      dest_ar <= wr_dest_ar;
      dest_pr <= wr_dest_pr;
    end else begin
      if (clr)   valid <= 1'b0;
      if (hit_a) rdy_a <= 1'b1;
      if (hit_b) rdy_b <= 1'b1;
    end
  end
endmodule

module mul_rs #(
  parameter int NUM_ENT = 4,
  parameter int PR_W    = 7
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     flush,
  mul_rs_if.slave  bus
);
  localparam int IDX_W = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;

  logic [1:0]                     cdb_vld;
  logic [1:0][PR_W-1:0]           cdb_tag;
  logic                           byp_a, byp_b;
  logic [NUM_ENT-1:0]             e_vld, e_rdy_a, e_rdy_b, e_wr, e_clr;
  logic [NUM_ENT-1:0][63:0]       e_npc;
  logic [NUM_ENT-1:0][31:0]       e_ir;
  logic [NUM_ENT-1:0][PR_W-1:0]   e_tag_a, e_tag_b, e_dest_pr;
  logic [NUM_ENT-1:0][4:0]        e_dest_ar;
  logic [NUM_ENT-1:0]             cand;
  logic                           free_found, cand_found;
  logic [IDX_W-1:0]               free_idx, sel_idx;
  logic                           do_disp, do_issue;
  logic                           unused_fu;

  assign cdb_vld = {bus.cdb_valid1, bus.cdb_valid0};
  assign cdb_tag = {bus.cdb_tag1, bus.cdb_tag0};

  // A broadcast in the dispatch cycle would be missed by the entry's own snoop.
  assign byp_a = (bus.cdb_valid0 && bus.cdb_tag0 == bus.id_pra_idx) ||
                 (bus.cdb_valid1 && bus.cdb_tag1 == bus.id_pra_idx);
  assign byp_b = (bus.cdb_valid0 && bus.cdb_tag0 == bus.id_prb_idx) ||
                 (bus.cdb_valid1 && bus.cdb_tag1 == bus.id_prb_idx);

  assign cand = e_vld & e_rdy_a & e_rdy_b;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    cand_found = 1'b0;
    sel_idx    = '0;
    for (int i = NUM_ENT - 1; i >= 0; i--) begin
      if (!e_vld[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (cand[i]) begin
        cand_found = 1'b1;
        sel_idx    = IDX_W'(i);
      end
    end
  end

  assign do_disp   = bus.id_valid && !bus.rs_full && !flush && free_found;
  assign do_issue  = cand_found && bus.fu_avail[0] && !flush;
  assign unused_fu = bus.fu_avail[1];

  for (genvar g = 0; g < NUM_ENT; g++) begin : g_ent
    assign e_wr[g]  = do_disp  && (free_idx == IDX_W'(g));
    assign e_clr[g] = do_issue && (sel_idx  == IDX_W'(g));

    mul_rs_ent #(.PR_W(PR_W)) u_ent (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .wr         (e_wr[g]),
      .clr        (e_clr[g]),
      .wr_npc     (bus.id_NPC),
      .wr_ir      (bus.id_IR),
      .wr_tag_a   (bus.id_pra_idx),
      .wr_rdy_a   (bus.id_pra_rdy | byp_a),
      .wr_tag_b   (bus.id_prb_idx),
      .wr_rdy_b   (bus.id_prb_rdy | byp_b),
      .wr_dest_ar (bus.id_dest_ar_idx),
      .wr_dest_pr (bus.id_dest_pr_idx),
      .cdb_vld    (cdb_vld),
      .cdb_tag    (cdb_tag),
      .valid      (e_vld[g]),
      .rdy_a      (e_rdy_a[g]),
      .rdy_b      (e_rdy_b[g]),
      .npc        (e_npc[g]),
      .ir         (e_ir[g]),
      .tag_a      (e_tag_a[g]),
      .tag_b      (e_tag_b[g]),
      .dest_ar    (e_dest_ar[g]),
      .dest_pr    (e_dest_pr[g])
    );
  end

  assign bus.rs_full = (bus.rs_count == 4'(NUM_ENT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.rs_valid_inst0  <= 1'b0;
      bus.rs_NPC0         <= '0;
      bus.rs_IR0          <= '0;
      bus.rs_pra_idx0     <= '0;
      bus.rs_prb_idx0     <= '0;
      bus.rs_dest_ar_idx0 <= '0;
      bus.rs_dest_pr_idx0 <= '0;
      bus.rs_count        <= '0;
    end else if (flush) begin
      bus.rs_valid_inst0 <= 1'b0;
      bus.rs_count       <= '0;
    end else begin
      bus.rs_valid_inst0 <= do_issue;
      bus.rs_count       <= bus.rs_count + {3'b000, do_disp} - {3'b000, do_issue};
      // Data outputs hold their last value when nothing issues.
      if (do_issue) begin
        bus.rs_NPC0         <= e_npc[sel_idx];
        bus.rs_IR0          <= e_ir[sel_idx];
        bus.rs_pra_idx0     <= e_tag_a[sel_idx];
        bus.rs_prb_idx0     <= e_tag_b[sel_idx];
        bus.rs_dest_ar_idx0 <= e_dest_ar[sel_idx];
        bus.rs_dest_pr_idx0 <= e_dest_pr[sel_idx];
      end
    end
  end
endmodule

// File: tb/tb_mul_rs.sv
// Directed bench for mul_rs: issued instructions are checked against a queue of
// expected issues, plus cycle-exact checks of valid/count/full.
module tb_mul_rs;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  typedef struct packed {
    logic [31:0] ir;
    logic [6:0]  dpr;
    logic [6:0]  pra;
    logic [6:0]  prb;
  } exp_t;
  exp_t exp_q[$];

  mul_rs_if #(.PR_W(7)) bus ();

  mul_rs #(.NUM_ENT(4), .PR_W(7)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic disp(input logic [31:0] ir, input logic [6:0] dpr,
                      input logic [6:0] pra, input logic ra,
                      input logic [6:0] prb, input logic rb, input logic push);
    bus.id_IR          = ir;
    bus.id_NPC         = {32'h0, ir} + 64'd4;
    bus.id_dest_ar_idx = ir[4:0];
    bus.id_dest_pr_idx = dpr;
    bus.id_pra_idx     = pra;
    bus.id_pra_rdy     = ra;
    bus.id_prb_idx     = prb;
    bus.id_prb_rdy     = rb;
    if (push) exp_q.push_back('{ir: ir, dpr: dpr, pra: pra, prb: prb});
    bus.id_valid = 1'b1;
    tick();
    bus.id_valid = 1'b0;
  endtask

  task automatic exp_push(input logic [31:0] ir, input logic [6:0] dpr,
                          input logic [6:0] pra, input logic [6:0] prb);
    exp_q.push_back('{ir: ir, dpr: dpr, pra: pra, prb: prb});
  endtask

  // Scoreboard: every issue pops the oldest expected instruction.
  always @(negedge clock) begin
    if (reset && bus.rs_valid_inst0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", {32'h0, bus.rs_IR0}, 64'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("iss_ir",  {32'h0, bus.rs_IR0}, {32'h0, e.ir});
        chk("iss_npc", bus.rs_NPC0, {32'h0, e.ir} + 64'd4);
        chk("iss_dpr", {57'h0, bus.rs_dest_pr_idx0}, {57'h0, e.dpr});
        chk("iss_pra", {57'h0, bus.rs_pra_idx0}, {57'h0, e.pra});
        chk("iss_prb", {57'h0, bus.rs_prb_idx0}, {57'h0, e.prb});
        chk("iss_dar", {59'h0, bus.rs_dest_ar_idx0}, {59'h0, e.ir[4:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.id_valid = 0; bus.id_NPC = '0; bus.id_IR = '0;
    bus.id_pra_idx = '0; bus.id_prb_idx = '0; bus.id_pra_rdy = 0; bus.id_prb_rdy = 0;
    bus.id_dest_ar_idx = '0; bus.id_dest_pr_idx = '0;
    bus.cdb_valid0 = 0; bus.cdb_valid1 = 0; bus.cdb_tag0 = '0; bus.cdb_tag1 = '0;
    bus.fu_avail = 2'b11;

    // Reset and idle
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", {63'h0, bus.rs_valid_inst0}, 64'h0);
    chk("rst_count", {60'h0, bus.rs_count}, 64'h0);
    chk("rst_full",  {63'h0, bus.rs_full}, 64'h0);
    chk("rst_ir",    {32'h0, bus.rs_IR0}, 64'h0);
    chk("rst_npc",   bus.rs_NPC0, 64'h0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_valid", {63'h0, bus.rs_valid_inst0}, 64'h0);
      chk("idle_count", {60'h0, bus.rs_count}, 64'h0);
    end

    // Ready dispatch: issue two edges after dispatch
    disp(32'h4C221403, 7'd12, 7'd1, 1'b1, 7'd2, 1'b1, 1'b1);
    chk("rdy_v_t",     {63'h0, bus.rs_valid_inst0}, 64'h0);
    chk("rdy_cnt_t",   {60'h0, bus.rs_count}, 64'd1);
    tick();
    chk("rdy_v_t1",    {63'h0, bus.rs_valid_inst0}, 64'h1);
    chk("rdy_ir",      {32'h0, bus.rs_IR0}, 64'h4C221403);
    chk("rdy_dpr",     {57'h0, bus.rs_dest_pr_idx0}, 64'd12);
    chk("rdy_cnt_t1",  {60'h0, bus.rs_count}, 64'd0);
    tick();
    chk("rdy_v_t2",    {63'h0, bus.rs_valid_inst0}, 64'h0);

    // Wake-up through CDB port 1
    disp(32'h11110001, 7'd20, 7'd5, 1'b0, 7'd6, 1'b1, 1'b0);
    tick();
    chk("wk_wait", {63'h0, bus.rs_valid_inst0}, 64'h0);
    bus.cdb_valid1 = 1'b1; bus.cdb_tag1 = 7'd5;
    exp_push(32'h11110001, 7'd20, 7'd5, 7'd6);
    tick();
    bus.cdb_valid1 = 1'b0;
    chk("wk_u",    {63'h0, bus.rs_valid_inst0}, 64'h0);
    tick();
    chk("wk_u1",   {63'h0, bus.rs_valid_inst0}, 64'h1);
    chk("wk_ir",   {32'h0, bus.rs_IR0}, 64'h11110001);
    chk("wk_cnt",  {60'h0, bus.rs_count}, 64'd0);

    // Same-cycle bypass on both operands, both CDB ports
    bus.cdb_valid0 = 1'b1; bus.cdb_tag0 = 7'd9;
    bus.cdb_valid1 = 1'b1; bus.cdb_tag1 = 7'd10;
    disp(32'h22220002, 7'd21, 7'd9, 1'b0, 7'd10, 1'b0, 1'b1);
    bus.cdb_valid0 = 1'b0; bus.cdb_valid1 = 1'b0;
    tick();
    chk("byp_v",  {63'h0, bus.rs_valid_inst0}, 64'h1);
    chk("byp_ir", {32'h0, bus.rs_IR0}, 64'h22220002);
    tick();

    // Fill, drop, then wake entry 2 via tag 0
    disp(32'hA0, 7'd40, 7'd30, 1'b0, 7'd50, 1'b1, 1'b0);
    disp(32'hA1, 7'd41, 7'd31, 1'b0, 7'd51, 1'b1, 1'b0);
    disp(32'hA2, 7'd42, 7'd0,  1'b0, 7'd52, 1'b1, 1'b0);
    disp(32'hA3, 7'd43, 7'd33, 1'b0, 7'd53, 1'b1, 1'b0);
    chk("full_cnt",  {60'h0, bus.rs_count}, 64'd4);
    chk("full_flag", {63'h0, bus.rs_full}, 64'h1);
    disp(32'hA4, 7'd44, 7'd34, 1'b1, 7'd54, 1'b1, 1'b0);
    chk("drop_cnt",  {60'h0, bus.rs_count}, 64'd4);
    tick();
    chk("drop_v",    {63'h0, bus.rs_valid_inst0}, 64'h0);
    bus.cdb_valid0 = 1'b1; bus.cdb_tag0 = 7'd0;
    exp_push(32'hA2, 7'd42, 7'd0, 7'd52);
    tick();
    bus.cdb_valid0 = 1'b0;
    tick();
    chk("e2_v",     {63'h0, bus.rs_valid_inst0}, 64'h1);
    chk("e2_ir",    {32'h0, bus.rs_IR0}, 64'hA2);
    chk("e2_cnt",   {60'h0, bus.rs_count}, 64'd3);
    chk("e2_full",  {63'h0, bus.rs_full}, 64'h0);
    tick();
    chk("e2_only",  {63'h0, bus.rs_valid_inst0}, 64'h0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl1_cnt",  {60'h0, bus.rs_count}, 64'd0);

    // Priority and stall on fu_avail[0]
    bus.fu_avail = 2'b10;
    disp(32'hB0, 7'd60, 7'd70, 1'b0, 7'd80, 1'b1, 1'b0);
    disp(32'hB1, 7'd61, 7'd71, 1'b1, 7'd81, 1'b1, 1'b1);
    disp(32'hB2, 7'd62, 7'd72, 1'b0, 7'd82, 1'b1, 1'b0);
    disp(32'hB3, 7'd63, 7'd73, 1'b1, 7'd83, 1'b1, 1'b1);
    tick();
    chk("stall_v",   {63'h0, bus.rs_valid_inst0}, 64'h0);
    chk("stall_cnt", {60'h0, bus.rs_count}, 64'd4);
    bus.fu_avail = 2'b11;
    tick();
    chk("pri1_v",   {63'h0, bus.rs_valid_inst0}, 64'h1);
    chk("pri1_ir",  {32'h0, bus.rs_IR0}, 64'hB1);
    chk("pri1_cnt", {60'h0, bus.rs_count}, 64'd3);
    tick();
    chk("pri3_ir",  {32'h0, bus.rs_IR0}, 64'hB3);
    chk("pri3_cnt", {60'h0, bus.rs_count}, 64'd2);

    // Dispatch and issue on the same edge: count nets zero
    disp(32'hC0, 7'd90, 7'd91, 1'b1, 7'd92, 1'b1, 1'b1);
    chk("sim_cnt0", {60'h0, bus.rs_count}, 64'd3);
    disp(32'hC1, 7'd93, 7'd94, 1'b1, 7'd95, 1'b1, 1'b1);
    chk("sim_ir0",  {32'h0, bus.rs_IR0}, 64'hC0);
    chk("sim_cnt1", {60'h0, bus.rs_count}, 64'd3);
    tick();
    chk("sim_ir1",  {32'h0, bus.rs_IR0}, 64'hC1);
    chk("sim_cnt2", {60'h0, bus.rs_count}, 64'd2);
    flush = 1'b1; tick(); flush = 1'b0;

    // Flush overrides pending issue and a same-cycle dispatch
    bus.fu_avail = 2'b00;
    disp(32'hD0, 7'd100, 7'd1, 1'b1, 7'd2, 1'b1, 1'b1);
    disp(32'hD1, 7'd101, 7'd1, 1'b1, 7'd2, 1'b1, 1'b0);
    disp(32'hD2, 7'd102, 7'd1, 1'b1, 7'd2, 1'b1, 1'b0);
    chk("fl_cnt3", {60'h0, bus.rs_count}, 64'd3);
    bus.fu_avail = 2'b11;
    tick();
    chk("fl_iss_ir", {32'h0, bus.rs_IR0}, 64'hD0);
    flush = 1'b1;
    disp(32'hD3, 7'd103, 7'd1, 1'b1, 7'd2, 1'b1, 1'b0);
    flush = 1'b0;
    chk("fl_v",   {63'h0, bus.rs_valid_inst0}, 64'h0);
    chk("fl_cnt", {60'h0, bus.rs_count}, 64'd0);
    tick();
    chk("fl_v2",  {63'h0, bus.rs_valid_inst0}, 64'h0);
    chk("fl_cnt2", {60'h0, bus.rs_count}, 64'd0);

    // Asynchronous reset between edges
    bus.fu_avail = 2'b00;
    disp(32'hE0, 7'd110, 7'd3, 1'b1, 7'd4, 1'b1, 1'b1);
    disp(32'hE1, 7'd111, 7'd3, 1'b1, 7'd4, 1'b1, 1'b0);
    bus.fu_avail = 2'b11;
    tick();
    chk("ar_pre_v", {63'h0, bus.rs_valid_inst0}, 64'h1);
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_v",    {63'h0, bus.rs_valid_inst0}, 64'h0);
    chk("ar_cnt",  {60'h0, bus.rs_count}, 64'd0);
    chk("ar_full", {63'h0, bus.rs_full}, 64'h0);
    chk("ar_ir",   {32'h0, bus.rs_IR0}, 64'h0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("ar_post_v",   {63'h0, bus.rs_valid_inst0}, 64'h0);
    chk("ar_post_cnt", {60'h0, bus.rs_count}, 64'd0);

    tick();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
